// File: rtl/packet_filter.sv
`default_nettype none
// ============================================================================
// Module      : packet_filter
// Description : Receives fixed-length packets one word per rx_valid/rx_ready
//               handshake, checks type, destination and source against this
//               node's ID, publishes the fields of accepted packets, pulses
//               'en' to the Q-table update stage and waits for its 'done'.
//               Accepted and dropped packets are counted with saturation.
// Ports       : clk, nrst (sync, active-high)  clock / reset
//               myNodeID                        this node's ID (static)
//               rx_word, rx_valid, rx_ready     packet word stream
//               fPacketType, fSourceID, fSourceHops, fClusterID,
//               fEnergyLeft, fQValue, fKnownCH  fields of last accepted packet
//               en, done                        update-stage start / finish
//               acceptCount, dropCount          saturating packet counters
// Revision    : 1.0  initial release
// ============================================================================
module packet_filter #(
  parameter int WORD_WIDTH = 16,
  parameter int PKT_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] rx_word,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fKnownCH,
  output logic [2:0]            fPacketType,
  output logic                  en,
  input  logic                  done,
  output logic [15:0]           acceptCount,
  output logic [15:0]           dropCount
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_WORDS - 1);

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2:0]            word_cnt;
  // Word 0 only contributes its type bits, so it is kept separately and the
  // staging array holds words 1..PKT_WORDS-1.
  logic [2:0]            stage_type;
  logic [WORD_WIDTH-1:0] stage [1:PKT_WORDS-1];
  logic                  pkt_ok;

  assign pkt_ok = (stage_type >= 3'd1) && (stage_type <= 3'd5) &&
                  ((stage[PKT_WORDS-1] == myNodeID) ||
                   (stage[PKT_WORDS-1] == {WORD_WIDTH{1'b1}})) &&
                  (stage[1] != myNodeID);

  // State register
  always_ff @(posedge clk) begin
    if (nrst) state <= RECV;
    else      state <= state_next;
  end

  // Next state and state-decoded outputs. In RECV rx_ready is high whenever
  // reset is released, so rx_valid alone marks a transfer there.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    en         = 1'b0;
    case (state)
      RECV: begin
        rx_ready = ~nrst;
        if (rx_valid && (word_cnt == LAST_IDX)) state_next = CHECK;
      end
      CHECK:   state_next = pkt_ok ? ISSUE : RECV;
      ISSUE: begin
        en         = ~nrst;
        state_next = WAIT;
      end
      WAIT:    if (done) state_next = RECV;
      default: state_next = RECV;
    endcase
  end

  // Word capture, field publication and counters
  always_ff @(posedge clk) begin
    if (nrst) begin
      word_cnt    <= 3'd0;
      stage_type  <= 3'd0;
      for (int i = 1; i < PKT_WORDS; i++) stage[i] <= '0;
      fPacketType <= 3'd0;
      fSourceID   <= '0;
      fSourceHops <= '0;
      fClusterID  <= '0;
      fEnergyLeft <= '0;
      fQValue     <= '0;
      fKnownCH    <= '0;
      acceptCount <= 16'd0;
      dropCount   <= 16'd0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (word_cnt == 3'd0) stage_type      <= rx_word[WORD_WIDTH-1 -: 3];
        else                  stage[word_cnt] <= rx_word;
        word_cnt <= (word_cnt == LAST_IDX) ? 3'd0 : word_cnt + 3'd1;
      end
      if (state == CHECK) begin
        if (pkt_ok) begin
          fPacketType <= stage_type;
          fSourceID   <= stage[1];
          fSourceHops <= stage[2];
          fClusterID  <= stage[3];
          fEnergyLeft <= stage[4];
          fQValue     <= stage[5];
          fKnownCH    <= stage[6];
          if (acceptCount != 16'hFFFF) acceptCount <= acceptCount + 16'd1;
        end else begin
          if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
